uart_apb_regs: RTL and testbench

//  Host-side APB3 slave that drives the uart_fifo host interface (tx_byte/transmit/rx_fifo_pop).

---
 rtl/uart_apb_regs.sv | 133 +++++++++++++
 tb/tb_uart_apb_regs.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_regs.sv
// APB3 slave mapping uart_fifo TX push / RX pop / status / irq control onto four word registers.
// Every access takes at least one wait state; DATA writes stall while the TX FIFO is full, up to TX_TIMEOUT cycles.
module uart_apb_regs #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int TX_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [7:0]        o_tx_byte,
    output logic              o_transmit,
    output logic              o_rx_fifo_pop,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_tx_fifo_full,
    input  logic              i_rx_fifo_empty,
    input  logic              i_uart_busy,
    input  logic              i_uart_irq,
    output logic              o_irq
);
    localparam int CNT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, TXWAIT, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_irq_en, r_sticky, r_uart_irq_q;
    logic               w_push, w_pop, w_err, w_load_rd, w_tx_load, w_en_we, w_st_clr, w_irq_rise;
    logic [DATA_W-1:0]  w_rdata;
    logic [1:0]         w_reg;

    assign w_reg      = i_paddr[1:0];
    assign w_irq_rise = i_uart_irq & ~r_uart_irq_q;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_load_rd   = 1'b0;
        w_tx_load   = 1'b0;
        w_en_we     = 1'b0;
        w_st_clr    = 1'b0;
        w_rdata     = '0;
        case (r_state)
            IDLE: if (i_psel && !i_penable) w_state_nxt = ACCESS;
            ACCESS: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                end else if (i_penable) begin
                    w_state_nxt = DONE;
                    if (i_pwrite) begin
                        case (w_reg)
                            2'd0: begin
                                w_tx_load = 1'b1;
                                if (i_tx_fifo_full) w_state_nxt = TXWAIT;
                                else                w_push      = 1'b1;
                            end
                            2'd2:    w_en_we  = 1'b1;
                            2'd3:    w_st_clr = i_pwdata[0];
                            default: ;
                        endcase
                    end else begin
                        w_load_rd = 1'b1;
                        case (w_reg)
                            2'd0: begin
                                // Empty FIFO reads as 0x100 with no pop; the head byte is not exposed.
                                w_rdata[8] = i_rx_fifo_empty;
                                if (!i_rx_fifo_empty) begin
                                    w_rdata[7:0] = i_rx_byte;
                                    w_pop        = 1'b1;
                                end
                            end
                            2'd1:    w_rdata[3:0] = {r_sticky, i_uart_busy, i_tx_fifo_full, i_rx_fifo_empty};
                            2'd2:    w_rdata[0]   = r_irq_en;
                            default: w_rdata[0]   = r_sticky;
                        endcase
                    end
                end
            end
            TXWAIT: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                end else if (!i_tx_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_W'(TX_TIMEOUT)) begin
                    w_err       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            o_prdata      <= '0;
            o_pready      <= 1'b0;
            o_pslverr     <= 1'b0;
            o_tx_byte     <= '0;
            o_transmit    <= 1'b0;
            o_rx_fifo_pop <= 1'b0;
            r_irq_en      <= 1'b0;
            r_sticky      <= 1'b0;
            r_uart_irq_q  <= 1'b0;
            o_irq         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= (r_state == TXWAIT) ? r_cnt + 1'b1 : '0;
            o_prdata      <= w_load_rd ? w_rdata : '0;
            o_pready      <= (w_state_nxt == DONE);
            o_pslverr     <= w_err;
            o_transmit    <= w_push;
            o_rx_fifo_pop <= w_pop;
            if (w_tx_load) o_tx_byte <= i_pwdata[7:0];
            if (w_en_we)   r_irq_en  <= i_pwdata[0];
            r_uart_irq_q  <= i_uart_irq;
            // A new event beats a simultaneous clear so it is never lost.
            r_sticky      <= w_irq_rise | (r_sticky & ~w_st_clr);
            o_irq         <= r_irq_en & r_sticky;
        end
    end
endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed bench for uart_apb_regs: TX push/stall/timeout, RX pop, status, irq sticky/W1C, psel drop, reset.
module tb_uart_apb_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_byte;
    logic        transmit, rx_fifo_pop;
    logic [7:0]  rx_byte = '0;
    logic        tx_full = 1'b0, rx_empty = 1'b1, busy = 1'b0, uart_irq = 1'b0;
    logic        irq;

    int vecs = 0;
    int miss = 0;
    int tx_cnt = 0, pop_cnt = 0, both_cnt = 0;
    logic [7:0] last_tx = '0;

    uart_apb_regs #(.DATA_W(16), .ADDR_W(2), .TX_TIMEOUT(255)) dut (
        .i_clk(clk), .i_rst(rst), .i_paddr(paddr), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
        .o_pslverr(pslverr), .o_tx_byte(tx_byte), .o_transmit(transmit),
        .o_rx_fifo_pop(rx_fifo_pop), .i_rx_byte(rx_byte), .i_tx_fifo_full(tx_full),
        .i_rx_fifo_empty(rx_empty), .i_uart_busy(busy), .i_uart_irq(uart_irq), .o_irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (transmit) begin
            tx_cnt  = tx_cnt + 1;
            last_tx = tx_byte;
        end
        if (rx_fifo_pop) pop_cnt = pop_cnt + 1;
        if (transmit && rx_fifo_pop) both_cnt = both_cnt + 1;
    end

    // One APB transfer; n = negedges after the enable phase until pready is seen.
    task automatic apb(input logic [1:0] a, input logic w, input logic [15:0] d, input int drop_at,
                       output logic [15:0] rd, output logic err, output int n);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        n = 0; rd = '0; err = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (pready) begin
                rd  = prdata;
                err = pslverr;
                break;
            end
            if (n == drop_at) tx_full = 1'b0;
            if (n > 600) begin
                vecs++; miss++;
                $display("FAIL apb_pready_timeout addr=%0d got no pready within %0d cycles", a, n);
                break;
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vecs++; if ({pready, pslverr, transmit, rx_fifo_pop, irq} !== 5'b0) begin miss++; $display("FAIL reset_ctrl got %b exp 00000", {pready, pslverr, transmit, rx_fifo_pop, irq}); end
        vecs++; if (prdata !== 16'h0) begin miss++; $display("FAIL reset_prdata got %h exp 0000", prdata); end
        vecs++; if (tx_byte !== 8'h0) begin miss++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_tx_write();
        logic [15:0] rd; logic err; int n; int t0;
        tx_full = 1'b0; t0 = tx_cnt;
        apb(2'd0, 1'b1, 16'h0041, -1, rd, err, n);
        vecs++; if (n !== 1) begin miss++; $display("FAIL tx_latency got %0d exp 1", n); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL tx_pslverr got %b exp 0", err); end
        vecs++; if (tx_cnt - t0 !== 1) begin miss++; $display("FAIL tx_push_count got %0d exp 1", tx_cnt - t0); end
        vecs++; if (last_tx !== 8'h41) begin miss++; $display("FAIL tx_byte got %h exp 41", last_tx); end
        vecs++; if (pready !== 1'b0) begin miss++; $display("FAIL tx_pready_one_cycle got %b exp 0", pready); end
    endtask

    task automatic test_tx_stall();
        logic [15:0] rd; logic err; int n; int t0;
        tx_full = 1'b1; t0 = tx_cnt;
        apb(2'd0, 1'b1, 16'h0055, 9, rd, err, n);
        vecs++; if (n !== 10) begin miss++; $display("FAIL stall_latency got %0d exp 10", n); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL stall_pslverr got %b exp 0", err); end
        vecs++; if (tx_cnt - t0 !== 1) begin miss++; $display("FAIL stall_push_count got %0d exp 1", tx_cnt - t0); end
        vecs++; if (last_tx !== 8'h55) begin miss++; $display("FAIL stall_tx_byte got %h exp 55", last_tx); end
    endtask

    task automatic test_tx_timeout();
        logic [15:0] rd; logic err; int n; int t0;
        tx_full = 1'b1; t0 = tx_cnt;
        apb(2'd0, 1'b1, 16'h0077, -1, rd, err, n);
        vecs++; if (n !== 257) begin miss++; $display("FAIL timeout_latency got %0d exp 257", n); end
        vecs++; if (err !== 1'b1) begin miss++; $display("FAIL timeout_pslverr got %b exp 1", err); end
        vecs++; if (tx_cnt - t0 !== 0) begin miss++; $display("FAIL timeout_push_count got %0d exp 0", tx_cnt - t0); end
        vecs++; if (pslverr !== 1'b0) begin miss++; $display("FAIL timeout_pslverr_clear got %b exp 0", pslverr); end
        tx_full = 1'b0;
    endtask

    task automatic test_rx_read();
        logic [15:0] rd; logic err; int n; int p0;
        rx_empty = 1'b0; rx_byte = 8'hA5; p0 = pop_cnt;
        apb(2'd0, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h00A5) begin miss++; $display("FAIL rx_data got %h exp 00a5", rd); end
        vecs++; if (pop_cnt - p0 !== 1) begin miss++; $display("FAIL rx_pop_count got %0d exp 1", pop_cnt - p0); end
        vecs++; if (prdata !== 16'h0) begin miss++; $display("FAIL rx_prdata_after got %h exp 0000", prdata); end
        rx_empty = 1'b1; p0 = pop_cnt;
        apb(2'd0, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0100) begin miss++; $display("FAIL rx_empty_data got %h exp 0100", rd); end
        vecs++; if (err !== 1'b0) begin miss++; $display("FAIL rx_empty_pslverr got %b exp 0", err); end
        vecs++; if (pop_cnt - p0 !== 0) begin miss++; $display("FAIL rx_empty_pop got %0d exp 0", pop_cnt - p0); end
    endtask

    task automatic test_status();
        logic [15:0] rd; logic err; int n;
        busy = 1'b1; tx_full = 1'b0; rx_empty = 1'b1;
        apb(2'd1, 1'b1, 16'hFFFF, -1, rd, err, n);
        apb(2'd1, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0005) begin miss++; $display("FAIL status_a got %h exp 0005", rd); end
        busy = 1'b0; tx_full = 1'b1; rx_empty = 1'b0;
        apb(2'd1, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0002) begin miss++; $display("FAIL status_b got %h exp 0002", rd); end
        tx_full = 1'b0; rx_empty = 1'b1;
    endtask

    task automatic test_irq();
        logic [15:0] rd; logic err; int n;
        apb(2'd2, 1'b1, 16'hFFFF, -1, rd, err, n);
        apb(2'd2, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0001) begin miss++; $display("FAIL irq_en_read got %h exp 0001", rd); end
        @(negedge clk); uart_irq = 1'b1;
        @(negedge clk); uart_irq = 1'b0;
        vecs++; if (irq !== 1'b0) begin miss++; $display("FAIL irq_registered_delay got %b exp 0", irq); end
        @(negedge clk);
        vecs++; if (irq !== 1'b1) begin miss++; $display("FAIL irq_assert got %b exp 1", irq); end
        apb(2'd3, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0001) begin miss++; $display("FAIL irq_st_set got %h exp 0001", rd); end
        apb(2'd1, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0009) begin miss++; $display("FAIL irq_status_pend got %h exp 0009", rd); end
        apb(2'd3, 1'b1, 16'h0001, -1, rd, err, n);
        vecs++; if (irq !== 1'b0) begin miss++; $display("FAIL irq_w1c got %b exp 0", irq); end
        apb(2'd3, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0000) begin miss++; $display("FAIL irq_st_clear got %h exp 0000", rd); end
        // Event edge lands on the same clock as the W1C clear.
        @(negedge clk); psel = 1'b1; penable = 1'b0; paddr = 2'd3; pwrite = 1'b1; pwdata = 16'h0001;
        @(negedge clk); penable = 1'b1; uart_irq = 1'b1;
        @(negedge clk); uart_irq = 1'b0;
        vecs++; if (pready !== 1'b1) begin miss++; $display("FAIL irq_race_pready got %b exp 1", pready); end
        @(negedge clk); psel = 1'b0; penable = 1'b0;
        vecs++; if (irq !== 1'b1) begin miss++; $display("FAIL irq_race_irq got %b exp 1", irq); end
        apb(2'd3, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0001) begin miss++; $display("FAIL irq_race_st got %h exp 0001", rd); end
    endtask

    task automatic test_psel_drop();
        logic [15:0] rd; logic err; int n; int t0; logic seen;
        tx_full = 1'b1; t0 = tx_cnt; seen = 1'b0;
        @(negedge clk); psel = 1'b1; penable = 1'b0; paddr = 2'd0; pwrite = 1'b1; pwdata = 16'h0099;
        @(negedge clk); penable = 1'b1;
        repeat (3) @(negedge clk);
        psel = 1'b0; penable = 1'b0; tx_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pready) seen = 1'b1;
        end
        vecs++; if (seen !== 1'b0) begin miss++; $display("FAIL drop_pready got %b exp 0", seen); end
        vecs++; if (tx_cnt - t0 !== 0) begin miss++; $display("FAIL drop_push got %0d exp 0", tx_cnt - t0); end
        apb(2'd0, 1'b1, 16'h0012, -1, rd, err, n);
        vecs++; if (n !== 1) begin miss++; $display("FAIL drop_recover_latency got %0d exp 1", n); end
        vecs++; if (last_tx !== 8'h12) begin miss++; $display("FAIL drop_recover_byte got %h exp 12", last_tx); end
    endtask

    task automatic test_reset_txwait();
        logic [15:0] rd; logic err; int n; int t0;
        tx_full = 1'b1;
        @(negedge clk); psel = 1'b1; penable = 1'b0; paddr = 2'd0; pwrite = 1'b1; pwdata = 16'h00AB;
        @(negedge clk); penable = 1'b1;
        repeat (5) @(negedge clk);
        vecs++; if (irq !== 1'b1) begin miss++; $display("FAIL rst_pre_irq got %b exp 1", irq); end
        #2 rst = 1'b1;
        #1;
        vecs++; if ({pready, pslverr, transmit, rx_fifo_pop, irq} !== 5'b0) begin miss++; $display("FAIL rst_txwait_ctrl got %b exp 00000", {pready, pslverr, transmit, rx_fifo_pop, irq}); end
        vecs++; if (tx_byte !== 8'h00) begin miss++; $display("FAIL rst_txwait_tx_byte got %h exp 00", tx_byte); end
        vecs++; if (prdata !== 16'h0) begin miss++; $display("FAIL rst_txwait_prdata got %h exp 0000", prdata); end
        psel = 1'b0; penable = 1'b0; tx_full = 1'b0;
        @(negedge clk); rst = 1'b0;
        t0 = tx_cnt;
        apb(2'd0, 1'b1, 16'h003C, -1, rd, err, n);
        vecs++; if (n !== 1 || err !== 1'b0) begin miss++; $display("FAIL rst_recover got n=%0d err=%b exp n=1 err=0", n, err); end
        vecs++; if (tx_cnt - t0 !== 1 || last_tx !== 8'h3C) begin miss++; $display("FAIL rst_recover_push got cnt=%0d byte=%h exp cnt=1 byte=3c", tx_cnt - t0, last_tx); end
        apb(2'd2, 1'b0, 16'h0, -1, rd, err, n);
        vecs++; if (rd !== 16'h0000) begin miss++; $display("FAIL rst_irq_en got %h exp 0000", rd); end
    endtask

    initial begin
        test_reset();
        test_tx_write();
        test_tx_stall();
        test_tx_timeout();
        test_rx_read();
        test_status();
        test_irq();
        test_psel_drop();
        test_reset_txwait();
        vecs++; if (both_cnt !== 0) begin miss++; $display("FAIL push_pop_overlap got %0d exp 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
